serial_twos_comp_rx: RTL and testbench

- Receive end of the serial two's-complement link.
- Accepts a WIDTH-bit word as an LSB-first serial bit stream, one bit per qualified clock.
- Applies the serial two's-complement rule on the fly: copy bits up to and including the first 1, invert every bit after it.
- Assembles the result into a parallel word. The rule is self-inverse, so it recovers the original operand from a complemented stream, and vice versa.

---
 rtl/serial_twos_comp_rx.sv | 85 ++++++++
 tb/tb_serial_twos_comp_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp_rx.sv
// Serial two's-complement receiver: takes an LSB-first word, copies bits up to
// and including the first 1, inverts the rest, and presents the parallel result.
module serial_twos_comp_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             start,
  input  logic             shift_control,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             o_bit;
  logic             last_bit;

  always_comb begin
    o_bit    = seen_one ? ~serial_in : serial_in;
    sr_nxt   = {o_bit, sr[WIDTH-1:1]};
    last_bit = shift_control && (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge Clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RECV;
      RECV:    if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
    done = (state == DONE);
  end

  // Counter parks at WIDTH-1 on the final bit so it never wraps.
  always_ff @(posedge Clock) begin
    if (reset) begin
      sr       <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
          end
        end
        RECV: begin
          if (shift_control) begin
            sr       <= sr_nxt;
            seen_one <= seen_one | serial_in;
            if (last_bit) data_out <= sr_nxt;
            else          cnt      <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_comp_rx.sv
// Directed and randomized checks of serial_twos_comp_rx against an arithmetic
// negation model: expected word is (2**WIDTH - operand) mod 2**WIDTH.
module tb_serial_twos_comp_rx;

  localparam int unsigned WIDTH = 8;

  logic             Clock;
  logic             reset;
  logic             start;
  logic             shift_control;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             done;
  logic             busy;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] prev_out;

  serial_twos_comp_rx #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .Clock         (Clock),
    .reset         (reset),
    .start         (start),
    .shift_control (shift_control),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .done          (done),
    .busy          (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [WIDTH-1:0] neg_ref(input logic [WIDTH-1:0] x);
    longint unsigned m;
    longint unsigned v;
    m = longint'(1) << WIDTH;
    v = (m - longint'(x)) % m;
    return v[WIDTH-1:0];
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ga/gb: bit index after which a gap of gl_a/gl_b idle cycles is inserted.
  // sb: bit index on which start is also pulsed (-1 for none).
  task automatic send_frame(input logic [WIDTH-1:0] w, input int ga, input int gl_a,
                            input int gb, input int gl_b, input int sb,
                            input logic start_in_done);
    logic [WIDTH-1:0] exp;
    exp = neg_ref(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    for (int i = 0; i < WIDTH; i++) begin
      shift_control = 1'b1;
      serial_in     = w[i];
      start         = (i == sb);
      tick();
      shift_control = 1'b0;
      start         = 1'b0;
      serial_in     = 1'($urandom);
      if (i < WIDTH - 1) begin
        chk("busy_in_frame", busy, 1);
        chk("done_early", done, 0);
        chk("data_out_hold", data_out, prev_out);
        if (i == ga) begin
          repeat (gl_a) begin
            tick();
            chk("busy_gap_a", busy, 1);
            chk("done_gap_a", done, 0);
          end
        end
        if (i == gb) begin
          repeat (gl_b) begin
            tick();
            chk("busy_gap_b", busy, 1);
            chk("done_gap_b", done, 0);
          end
        end
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("data_out_result", data_out, exp);
    prev_out = exp;
    start = start_in_done;
    tick();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("data_out_after_done", data_out, prev_out);
    if (start_in_done) begin
      tick();
      chk("start_in_done_ignored", busy, 0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    shift_control = 1'b0;
    serial_in     = 1'b0;
    prev_out      = '0;

    tick();
    tick();
    reset = 1'b0;
    chk("reset_data_out", data_out, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);

    send_frame(8'h0A, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'hF6, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'h01, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'h00, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'h80, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'hFF, -1, 0, -1, 0, -1, 1'b1);

    send_frame(8'h0A, 2, 3, 5, 1, -1, 1'b0);
    send_frame(8'h0A, -1, 0, -1, 0, 4, 1'b0);

    shift_control = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serial_in = 1'($urandom);
      tick();
      chk("idle_shift_busy", busy, 0);
      chk("idle_shift_done", done, 0);
      chk("idle_shift_hold", data_out, prev_out);
    end
    shift_control = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_control = 1'b1;
      serial_in     = i[0] ^ 1'b0 ? 1'b1 : 1'b0;
      tick();
    end
    shift_control = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prev_out = '0;
    chk("midreset_data_out", data_out, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      shift_control = 1'b1;
      tick();
      chk("midreset_no_done", done, 0);
    end
    shift_control = 1'b0;
    send_frame(8'h33, -1, 0, -1, 0, -1, 1'b0);
    send_frame(8'h7F, -1, 0, -1, 0, -1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      send_frame(WIDTH'($urandom), int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2 * WIDTH)) - WIDTH, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
